bpm_flag_monitor: RTL and testbench
===================================

// Module: bpm_flag_monitor
// PURPOSE
//  Upstream stage of the misapplication drive logic. Measures the inter-beat interval (IBI) from the pulse sensor.
//  Produces a qualified bpm_flag (abnormal heart rate or lost pulse) for the pedal/physiology combiner.
//  Debounces with refractory rejection and N-consecutive-beat hysteresis, so single glitches never raise the flag.
// PARAMETERS
//  CLK_FREQ     125_000_000  clock Hz; cycle thresholds derived as localparams
//  BPM_HIGH     120          above this = abnormal; IBI_MIN = CLK_FREQ*60/BPM_HIGH
//  BPM_LOW      40           below this = abnormal; IBI_MAX = CLK_FREQ*60/BPM_LOW
//  REFRACT_MS   200          beats closer than this to last accepted beat are ignored
//  TIMEOUT_SEC  3            no accepted beat for this long = pulse lost
//  CONSEC_N     3            consecutive abnormal/normal intervals to set/clear flag; legal range 1..15
// PORTS
//  clk          in   1   system clock
//  rst_n        in   1   synchronous, active-low reset
//  mon_en       in   1   monitor enable; low forces idle
//  beat_in      in   1   raw sensor beat pulse, asynchronous
//  bpm_flag     out  1   qualified abnormal-rate / lost-pulse flag
//  ibi_cycles   out  32  last measured IBI in clocks
//  ibi_valid    out  1   1-cycle strobe when ibi_cycles updates
//  mon_state    out  2   current FSM state, for debug
// BEHAVIOUR
//  - Reset values: bpm_flag=0, ibi_cycles=0, ibi_valid=0, mon_state=S_IDLE. All internal counters are also 0.
//  - Input path: beat_in passes a 2-FF synchronizer, then rising-edge detect.
//    The beat event fires 3 clks after beat_in rises at a sampling edge. Level-held input gives exactly one event.
//  - ibi_cnt (32b): loads 1 on an accepted beat, else +1 per clk. Saturates at 32'hFFFF_FFFF.
//  - Refractory: in S_TRACK/S_ALARM, an event with ibi_cnt < REFRACT_CYC is dropped. No counter or state change.
//  - Classification: an interval is abnormal if ibi_cnt < IBI_MIN or ibi_cnt > IBI_MAX. Equality is normal.
//  - On an accepted beat in S_TRACK/S_ALARM: ibi_cycles<=ibi_cnt and ibi_valid=1 for the following cycle.
//  - abn_cnt and norm_cnt are 4b and saturating. An abnormal interval clears norm_cnt; a normal interval clears abn_cnt.
//  - FSM:
//    S_IDLE  : flag 0. First event -> S_TRACK, ibi_cnt<=1, no ibi_valid, no refractory. Timeout is not checked here.
//    S_TRACK : flag 0. The CONSEC_N-th consecutive abnormal interval -> S_ALARM; bpm_flag=1 on the next clk.
//    S_ALARM : flag 1. The CONSEC_N-th consecutive normal interval -> S_TRACK; bpm_flag=0 on the next clk.
//    S_LOST  : flag 1. Next event -> S_ALARM, ibi_cnt<=1, norm_cnt<=0, no ibi_valid.
//  - Timeout: in S_TRACK/S_ALARM, when ibi_cnt == TIMEOUT_CYC -> S_LOST with bpm_flag=1.
//  - A beat and a timeout in the same cycle: the beat wins.
//  - mon_en=0 (any time, including mid-alarm): next clk S_IDLE, bpm_flag=0, counters cleared. ibi_cycles is held.
//  - The synchronizer keeps running while mon_en=0. An edge already in flight when mon_en rises counts as the first beat.
//  - Reset mid-operation: identical to the reset values above on the next clk.
// CONFIGURATION
//  - BPM_MON_TIMEOUT_EN defined: timeout path and S_LOST are implemented as above.
//  - Not defined: no timeout; S_LOST is unreachable and absent from the FSM.
//    Loss of pulse leaves the flag at its current value; ibi_cnt still saturates.
// STRUCTURE
//  - Shared package misapp_pkg holds: state encodings (S_IDLE=2'b00, S_TRACK=2'b01, S_ALARM=2'b10, S_LOST=2'b11),
//    the default CLK_FREQ, and the cycles-per-ms/sec helper constants.
//  - One sub-module: beat_sync_edge, which contains the 2-FF synchronizer and the rising-edge pulse generator.
//    The IBI counter, classifier and FSM stay in this module.
// TESTING  (CLK_FREQ=1000: IBI_MIN=500, IBI_MAX=1500, REFRACT=200, TIMEOUT=3000)
//  - Beats every 1000 clks x10 -> 9 ibi_valid strobes with ibi_cycles=1000; bpm_flag stays 0; state S_TRACK.
//  - Beats every 400 clks -> bpm_flag rises 1 clk after the 4th beat event (3rd abnormal IBI); state S_ALARM.
//  - From alarm, beats every 1000 -> flag stays 1 through 2 normal IBIs and clears after the 3rd.
//    An abnormal IBI mid-sequence restarts the count.
//  - Extra pulse 100 clks after a beat, in a 1000-clk rhythm -> ignored; next ibi_cycles=1000; no flag change.
//  - Beats stop in S_TRACK -> with EN, bpm_flag=1 exactly 3000 clks after the last beat, state S_LOST.
//    Without EN, the flag stays 0.
//  - mon_en dropped for 1 clk during S_ALARM -> flag 0 and S_IDLE next clk. On re-enable, the first beat gives no ibi_valid.

Source files
------------

// File: rtl/misapp_pkg.sv
// Shared definitions for the misapplication drive logic: monitor state encodings,
// default clock frequency and clock-cycle conversion helpers.
package misapp_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_TRACK = 2'b01,
    S_ALARM = 2'b10,
    S_LOST  = 2'b11
  } mon_state_t;

  localparam int unsigned     DEFAULT_CLK_FREQ = 125_000_000;
  localparam longint unsigned MS_PER_SEC       = 64'd1000;
  localparam longint unsigned SEC_PER_MIN      = 64'd60;

  function automatic longint unsigned cycles_per_ms(input longint unsigned clk_freq);
    return clk_freq / MS_PER_SEC;
  endfunction

  function automatic longint unsigned cycles_per_sec(input longint unsigned clk_freq);
    return clk_freq;
  endfunction

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/beat_sync_edge.sv
// Brings the asynchronous pulse-sensor beat into the clk domain and emits a
// registered one-cycle event on each rising edge; a held level gives one event.
module beat_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic beat_in,
  output logic beat_evt
);

  logic sync1;
  logic sync2;
  logic sync3;

  // NOTE: sync1/sync2 form the metastability chain; only sync2 onward may feed logic.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      sync3    <= 1'b0;
      beat_evt <= 1'b0;
    end else begin
      sync1    <= beat_in;
      sync2    <= sync1;
      sync3    <= sync2;
      beat_evt <= sync2 & ~sync3;
    end
  end

endmodule

// File: rtl/bpm_flag_monitor.sv
// Heart-rate monitor: measures inter-beat interval and raises a debounced bpm_flag
// on abnormal rate (and, with BPM_MON_TIMEOUT_EN defined, on lost pulse).
module bpm_flag_monitor
  import misapp_pkg::*;
#(
  parameter int unsigned CLK_FREQ    = DEFAULT_CLK_FREQ,
  parameter int unsigned BPM_HIGH    = 120,
  parameter int unsigned BPM_LOW     = 40,
  parameter int unsigned REFRACT_MS  = 200,
  parameter int unsigned TIMEOUT_SEC = 3,
  parameter int unsigned CONSEC_N    = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mon_en,
  input  logic        beat_in,
  output logic        bpm_flag,
  output logic [31:0] ibi_cycles,
  output logic        ibi_valid,
  output logic [1:0]  mon_state
);

  localparam longint unsigned CLK_HZ = 64'(CLK_FREQ);

  // A fast heart rate means a short interval, hence BPM_HIGH sets the lower IBI bound.
  localparam logic [31:0] IBI_MIN     = 32'(CLK_HZ * SEC_PER_MIN / 64'(BPM_HIGH));
  localparam logic [31:0] IBI_MAX     = 32'(CLK_HZ * SEC_PER_MIN / 64'(BPM_LOW));
  localparam logic [31:0] REFRACT_CYC = 32'(64'(REFRACT_MS) * cycles_per_ms(CLK_HZ));
  localparam logic [3:0]  CONSEC_LIM  = 4'(CONSEC_N);
`ifdef BPM_MON_TIMEOUT_EN
  localparam logic [31:0] TIMEOUT_CYC = 32'(64'(TIMEOUT_SEC) * cycles_per_sec(CLK_HZ));
`endif

  if (CONSEC_N < 1 || CONSEC_N > 15 || BPM_LOW >= BPM_HIGH || TIMEOUT_SEC == 0) begin : g_bad_cfg
    $error("bpm_flag_monitor: illegal parameter set");
  end

  logic        beat_evt;
  mon_state_t  state_q, state_d;
  logic [31:0] ibi_cnt_q, ibi_cnt_d;
  logic [3:0]  abn_q, abn_d;
  logic [3:0]  norm_q, norm_d;
  logic [31:0] ibi_cycles_d;
  logic        ibi_valid_d;

  logic        abnormal;
  logic        in_refract;
  logic [3:0]  abn_inc;
  logic [3:0]  norm_inc;

  beat_sync_edge u_beat_sync_edge (
    .clk      (clk),
    .rst_n    (rst_n),
    .beat_in  (beat_in),
    .beat_evt (beat_evt)
  );

  assign abnormal   = (ibi_cnt_q < IBI_MIN) || (ibi_cnt_q > IBI_MAX);
  assign in_refract = (ibi_cnt_q < REFRACT_CYC);
  assign abn_inc    = sat_inc4(abn_q);
  assign norm_inc   = sat_inc4(norm_q);
  assign mon_state  = state_q;

  // NOTE: every always_comb output is defaulted first so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    ibi_cnt_d    = sat_inc32(ibi_cnt_q);
    abn_d        = abn_q;
    norm_d       = norm_q;
    ibi_cycles_d = ibi_cycles;
    ibi_valid_d  = 1'b0;

    if (!mon_en) begin
      state_d   = S_IDLE;
      ibi_cnt_d = '0;
      abn_d     = '0;
      norm_d    = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          ibi_cnt_d = '0;
          if (beat_evt) begin
            state_d   = S_TRACK;
            ibi_cnt_d = 32'd1;
          end
        end

        S_TRACK, S_ALARM: begin
          if (beat_evt && !in_refract) begin
            ibi_cnt_d    = 32'd1;
            ibi_cycles_d = ibi_cnt_q;
            ibi_valid_d  = 1'b1;
            if (abnormal) begin
              abn_d  = abn_inc;
              norm_d = '0;
              if (state_q == S_TRACK && abn_inc >= CONSEC_LIM) state_d = S_ALARM;
            end else begin
              norm_d = norm_inc;
              abn_d  = '0;
              if (state_q == S_ALARM && norm_inc >= CONSEC_LIM) state_d = S_TRACK;
            end
          end
`ifdef BPM_MON_TIMEOUT_EN
          // Checked only when no beat is accepted, so a coincident beat wins.
          else if (ibi_cnt_q == TIMEOUT_CYC) begin
            state_d = S_LOST;
          end
`endif
        end

`ifdef BPM_MON_TIMEOUT_EN
        S_LOST: begin
          if (beat_evt) begin
            state_d   = S_ALARM;
            ibi_cnt_d = 32'd1;
            norm_d    = '0;
          end
        end
`endif

        default: begin
          state_d   = S_IDLE;
          ibi_cnt_d = '0;
          abn_d     = '0;
          norm_d    = '0;
        end
      endcase
    end
  end

  // NOTE: state uses non-blocking assignments so all registers update from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ibi_cnt_q  <= '0;
      abn_q      <= '0;
      norm_q     <= '0;
      ibi_cycles <= '0;
      ibi_valid  <= 1'b0;
      bpm_flag   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ibi_cnt_q  <= ibi_cnt_d;
      abn_q      <= abn_d;
      norm_q     <= norm_d;
      ibi_cycles <= ibi_cycles_d;
      ibi_valid  <= ibi_valid_d;
      bpm_flag   <= (state_d == S_ALARM) || (state_d == S_LOST);
    end
  end

endmodule

// File: tb/tb_bpm_flag_monitor.sv
// Directed bench for bpm_flag_monitor at CLK_FREQ=1000 (IBI_MIN=500, IBI_MAX=1500,
// refractory 200, timeout 3000); ibi strobes are scored against a queue of expected IBIs.
module tb_bpm_flag_monitor;
  import misapp_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mon_en;
  logic        beat_in;
  logic        bpm_flag;
  logic [31:0] ibi_cycles;
  logic        ibi_valid;
  logic [1:0]  mon_state;

  int          n_pass  = 0;
  int          n_total = 0;
  logic [31:0] sb_q[$];

  always #5 clk = ~clk;

  bpm_flag_monitor #(
    .CLK_FREQ   (1000),
    .BPM_HIGH   (120),
    .BPM_LOW    (40),
    .REFRACT_MS (200),
    .TIMEOUT_SEC(3),
    .CONSEC_N   (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mon_en    (mon_en),
    .beat_in   (beat_in),
    .bpm_flag  (bpm_flag),
    .ibi_cycles(ibi_cycles),
    .ibi_valid (ibi_valid),
    .mon_state (mon_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Monitor: every ibi_valid strobe must match the oldest expected interval.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && ibi_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_ibi_valid: got ibi_cycles=%0d, expected no strobe", ibi_cycles);
      end else begin
        check("ibi_cycles", ibi_cycles, sb_q.pop_front());
      end
    end
  end

  // Called just after a posedge (edge k). The event is acted on at edge k+4.
  task automatic beat(input string name, input int gap, input bit push, input logic [31:0] exp_ibi,
                      input logic pre_flag, input logic post_flag, input mon_state_t post_state);
    if (push) sb_q.push_back(exp_ibi);
    beat_in = 1'b1;
    repeat (4) @(negedge clk);
    check({name, "_flag_pre"}, 32'(bpm_flag), 32'(pre_flag));
    @(negedge clk);
    check({name, "_flag"}, 32'(bpm_flag), 32'(post_flag));
    check({name, "_state"}, 32'(mon_state), 32'(post_state));
    @(posedge clk);
    #1;
    beat_in = 1'b0;
    repeat (gap - 5) @(posedge clk);
    #1;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: got no end of run, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n   = 1'b0;
    mon_en  = 1'b0;
    beat_in = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_flag", 32'(bpm_flag), 32'd0);
    check("rst_ibi_cycles", ibi_cycles, 32'd0);
    check("rst_ibi_valid", 32'(ibi_valid), 32'd0);
    check("rst_state", 32'(mon_state), 32'(S_IDLE));
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("idle_wait_state", 32'(mon_state), 32'(S_IDLE));

    // Normal rhythm, then the last gap switches to 400 to start the fast run.
    for (int i = 1; i <= 10; i++) begin
      beat($sformatf("norm%0d", i), (i == 10) ? 400 : 1000, (i > 1), 32'd1000,
           1'b0, 1'b0, S_TRACK);
    end

    // Three abnormal 400-clk intervals raise the flag on the third.
    beat("fast1", 400, 1'b1, 32'd400, 1'b0, 1'b0, S_TRACK);
    beat("fast2", 400, 1'b1, 32'd400, 1'b0, 1'b0, S_TRACK);
    beat("fast3", 1000, 1'b1, 32'd400, 1'b0, 1'b1, S_ALARM);

    // Recovery with one abnormal interval restarting the normal count.
    beat("rec1", 1000, 1'b1, 32'd1000, 1'b1, 1'b1, S_ALARM);
    beat("rec2", 400, 1'b1, 32'd1000, 1'b1, 1'b1, S_ALARM);
    beat("rec_abn", 1000, 1'b1, 32'd400, 1'b1, 1'b1, S_ALARM);
    beat("rec3", 1000, 1'b1, 32'd1000, 1'b1, 1'b1, S_ALARM);
    beat("rec4", 1000, 1'b1, 32'd1000, 1'b1, 1'b1, S_ALARM);
    beat("rec5", 100, 1'b1, 32'd1000, 1'b1, 1'b0, S_TRACK);

    // Glitch inside the refractory window is dropped.
    beat("glitch", 900, 1'b0, 32'd0, 1'b0, 1'b0, S_TRACK);
    beat("post_glitch", 6, 1'b1, 32'd1000, 1'b0, 1'b0, S_TRACK);

    // Beats stop: last accepted beat was acted on 3000 edges before the timeout edge.
    repeat (2998) @(negedge clk);
    check("timeout_pre_flag", 32'(bpm_flag), 32'd0);
    check("timeout_pre_state", 32'(mon_state), 32'(S_TRACK));
    @(negedge clk);
`ifdef BPM_MON_TIMEOUT_EN
    check("timeout_flag", 32'(bpm_flag), 32'd1);
    check("timeout_state", 32'(mon_state), 32'(S_LOST));
`else
    check("timeout_flag", 32'(bpm_flag), 32'd0);
    check("timeout_state", 32'(mon_state), 32'(S_TRACK));
`endif
    @(posedge clk);
    #1;

`ifdef BPM_MON_TIMEOUT_EN
    beat("lost_exit", 400, 1'b0, 32'd0, 1'b1, 1'b1, S_ALARM);
`else
    beat("long_ibi", 400, 1'b1, 32'd3005, 1'b0, 1'b0, S_TRACK);
    beat("re_fast1", 400, 1'b1, 32'd400, 1'b0, 1'b0, S_TRACK);
    beat("re_fast2", 400, 1'b1, 32'd400, 1'b0, 1'b1, S_ALARM);
`endif

    // One-cycle enable drop in alarm.
    mon_en = 1'b0;
    @(negedge clk);
    check("drop_pre_flag", 32'(bpm_flag), 32'd1);
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    @(negedge clk);
    check("drop_flag", 32'(bpm_flag), 32'd0);
    check("drop_state", 32'(mon_state), 32'(S_IDLE));
    check("drop_ibi_valid", 32'(ibi_valid), 32'd0);
`ifdef BPM_MON_TIMEOUT_EN
    check("drop_ibi_held", ibi_cycles, 32'd1000);
`else
    check("drop_ibi_held", ibi_cycles, 32'd400);
`endif
    repeat (20) @(posedge clk);
    #1;
    beat("reen_first", 1000, 1'b0, 32'd0, 1'b0, 1'b0, S_TRACK);
    beat("reen_second", 6, 1'b1, 32'd1000, 1'b0, 1'b0, S_TRACK);

    // Reset in mid-operation.
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_flag", 32'(bpm_flag), 32'd0);
    check("midrst_ibi_cycles", ibi_cycles, 32'd0);
    check("midrst_ibi_valid", 32'(ibi_valid), 32'd0);
    check("midrst_state", 32'(mon_state), 32'(S_IDLE));
    rst_n = 1'b1;

    repeat (5) @(negedge clk);
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
